// File: rtl/line_scheduler.sv
// Line scheduler: pops lines, feeds the filter engine, then commits or requeues
// each result while tracking pass progress to detect solved/stuck/contradiction.
module line_scheduler #(
  parameter int SIZE   = 11,
  parameter int LINE_W = 1024,
  parameter int IDX_W  = $clog2(2*SIZE),
  parameter int CNT_W  = 8,
  parameter int OPT_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              fifo_empty,
  input  logic              fifo_full,
  input  logic [CNT_W-1:0]  fifo_count,
  output logic              fifo_rd_en,
  input  logic [LINE_W-1:0] fifo_dout,
  output logic              fifo_wr_en,
  output logic [LINE_W-1:0] fifo_din,
  output logic              flt_valid,
  input  logic              flt_ready,
  output logic [LINE_W-1:0] flt_line,
  input  logic              res_valid,
  input  logic [LINE_W-1:0] res_line,
  input  logic [OPT_W-1:0]  res_opts,
  input  logic              res_changed,
  output logic              commit_en,
  output logic [IDX_W-1:0]  commit_idx,
  output logic              busy,
  output logic              solved,
  output logic              stuck,
  output logic              error,
  output logic [15:0]       pass_cnt
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_POP,
    S_WAIT_RD,
    S_ISSUE,
    S_WAIT_RES,
    S_COMMIT,
    S_REQUEUE,
    S_CHECK,
    S_DONE,
    S_STUCK,
    S_ERROR
  } state_t;

  state_t             state;
  state_t             state_d;
  logic [CNT_W-1:0]   pass_rem;
  logic [CNT_W-1:0]   rem_dec;
  logic               progress;
  logic               changed_q;
  logic [LINE_W-1:0]  res_q;
  logic               idle_like;

  assign rem_dec    = (pass_rem == '0) ? '0 : pass_rem - 1'b1;
  assign idle_like  = (state == S_IDLE) || (state == S_DONE) ||
                      (state == S_STUCK) || (state == S_ERROR);
  assign fifo_din   = res_q;
  assign commit_idx = res_q[LINE_W-1 -: IDX_W];
  assign busy       = !idle_like;
  assign solved     = (state == S_DONE);
  assign stuck      = (state == S_STUCK);
  assign error      = (state == S_ERROR);

  always_comb begin
    state_d    = state;
    fifo_rd_en = 1'b0;
    fifo_wr_en = 1'b0;
    flt_valid  = 1'b0;
    commit_en  = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_STUCK, S_ERROR: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = (fifo_count == '0) ? S_DONE : S_POP;
      end
      S_POP: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = S_WAIT_RD;
        end else begin
          state_d = S_CHECK;
        end
      end
      S_WAIT_RD: state_d = S_ISSUE;
      S_ISSUE: begin
        flt_valid = 1'b1;
        if (flt_ready) state_d = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        if (res_valid) begin
          if (res_opts == '0)
            state_d = S_ERROR;
          else if (res_opts == OPT_W'(1))
            state_d = S_COMMIT;
          else
            state_d = S_REQUEUE;
        end
      end
      S_COMMIT: begin
        commit_en = 1'b1;
        state_d   = S_CHECK;
      end
      S_REQUEUE: begin
        if (!fifo_full) begin
          fifo_wr_en = 1'b1;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (rem_dec != '0)
          state_d = S_POP;
        else if (fifo_empty)
          state_d = S_DONE;
        else if (!progress)
          state_d = S_STUCK;
        else
          state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pass_rem  <= '0;
      progress  <= 1'b0;
      changed_q <= 1'b0;
      res_q     <= '0;
      flt_line  <= '0;
      pass_cnt  <= '0;
    end else begin
      state <= state_d;
      if (idle_like && start) pass_cnt <= '0;
      if (state == S_LOAD) begin
        pass_rem <= fifo_count;
        progress <= 1'b0;
      end
      if (state == S_WAIT_RD) flt_line <= fifo_dout;
      if (state == S_WAIT_RES && res_valid) begin
        res_q     <= res_line;
        changed_q <= res_changed;
      end
      if (state == S_COMMIT) progress <= 1'b1;
      if (state == S_REQUEUE && !fifo_full)
        progress <= progress | changed_q;
      if (state == S_CHECK) begin
        pass_rem <= rem_dec;
        if (rem_dec == '0) pass_cnt <= pass_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/line_scheduler.md
Name: line_scheduler

Overview:
Sequencing controller for the nonogram line-elimination loop. It pops line records from the line FIFO and hands each one to the line filter engine over a valid/ready handshake. When the filtered result returns, it either requeues the line or commits it to the board. It tracks per-pass progress so it can declare the puzzle solved, stuck (no progress in a full pass), or contradictory.

Parameters:
SIZE, 11, board edge length; line indices 0..SIZE-1 are rows, SIZE..2*SIZE-1 are columns
LINE_W, 1024, line record width; bits [LINE_W-1 -: IDX_W] hold the line index
IDX_W, $clog2(2*SIZE), line index field width (5 at default)
CNT_W, 8, FIFO occupancy width; also the width of the pass-remaining counter
OPT_W, 7, option-count width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  begin a run; sampled only in IDLE
fifo_empty  in  1  line FIFO empty
fifo_full  in  1  line FIFO full
fifo_count  in  CNT_W  current FIFO occupancy
fifo_rd_en  out  1  pop strobe; FIFO data is valid the following cycle
fifo_dout  in  LINE_W  popped line record
fifo_wr_en  out  1  requeue strobe
fifo_din  out  LINE_W  requeued line record
flt_valid  out  1  line offered to the filter
flt_ready  in  1  filter accepts the line
flt_line  out  LINE_W  registered line record sent to the filter
res_valid  in  1  filter result pulse
res_line  in  LINE_W  filtered line record (surviving options packed)
res_opts  in  OPT_W  surviving option count
res_changed  in  1  filter removed at least one option
commit_en  out  1  one-cycle pulse: write the single surviving option to the board
commit_idx  out  IDX_W  line index being committed
busy  out  1  a run is in progress
solved  out  1  sticky: queue drained
stuck  out  1  sticky: a full pass completed with no progress
error  out  1  sticky: a line returned zero options
pass_cnt  out  16  number of completed passes in the current run

Behaviour:
- Reset: state IDLE. All outputs 0, including flt_line, fifo_din, commit_idx and pass_cnt. Internal progress flag and pass_rem are cleared. Reset mid-run aborts the run immediately; no strobe is issued in the following cycle.
- IDLE:
  - start=1 moves to LOAD, clears solved/stuck/error and pass_cnt, and sets busy=1.
  - start outside IDLE is ignored.
- LOAD:
  - pass_rem <= fifo_count and progress <= 0.
  - If fifo_count==0, go to DONE; otherwise go to POP.
- POP:
  - Assert fifo_rd_en for exactly one cycle, only if !fifo_empty, then go to WAIT_RD.
  - If fifo_empty, go to CHECK without decrementing pass_rem.
- WAIT_RD: capture flt_line <= fifo_dout, then go to ISSUE.
- ISSUE:
  - Hold flt_valid=1 and flt_line stable until flt_ready=1 in the same cycle.
  - On that handshake, go to WAIT_RES with flt_valid=0 the next cycle.
- WAIT_RES:
  - Wait for res_valid; res_valid in any other state is ignored.
  - On res_valid, latch res_line, res_opts and res_changed.
  - res_opts==0: go to ERROR.
  - res_opts==1: go to COMMIT.
  - res_opts>=2: go to REQUEUE.
- COMMIT:
  - commit_en=1 for one cycle, with commit_idx = latched res_line[LINE_W-1 -: IDX_W].
  - progress <= 1; go to CHECK.
- REQUEUE:
  - If !fifo_full: fifo_wr_en=1 for one cycle with fifo_din = latched res_line; progress <= progress | res_changed; go to CHECK.
  - If fifo_full: stay in REQUEUE with fifo_wr_en=0 until space is available.
- CHECK:
  - Decrement pass_rem (saturating at 0).
  - If the decremented value is >0, go to POP.
  - Otherwise the pass ends and pass_cnt increments:
    - fifo_empty: go to DONE.
    - progress==0: go to STUCK.
    - else: go to LOAD for a new pass.
- DONE / STUCK / ERROR:
  - Set solved / stuck / error respectively and set busy=0.
  - The flag is sticky until the next start or rst; start returns to LOAD via IDLE semantics.
- Only one line is in flight at a time. fifo_rd_en and fifo_wr_en are never asserted in the same cycle. commit_en and fifo_wr_en are mutually exclusive.
- Minimum latency from start to first fifo_rd_en is 2 cycles (LOAD, POP).
- Per-line overhead outside the filter is 5 cycles (POP, WAIT_RD, ISSUE≥1, COMMIT/REQUEUE, CHECK).
- pass_cnt wraps at 2^16.

Test Plan:
- Empty queue: start with fifo_count=0 -> solved=1 by the 2nd cycle after start; no fifo_rd_en, flt_valid or commit_en; pass_cnt=0.
- Single line, index 3, filter returns res_opts=1 -> one fifo_rd_en, one commit_en with commit_idx=3, no fifo_wr_en, solved=1, pass_cnt=1.
- Two lines (indices 12, 5) each returning res_opts=2 with res_changed=0 -> both requeued in order 12, 5; stuck=1 after pass 1; pass_cnt=1; commit_en never asserted.
- Handshake backpressure: hold flt_ready=0 for 4 cycles -> flt_valid stays 1 and flt_line stays constant for 4 cycles; a res_valid pulse during ISSUE is ignored; transfer completes on the 5th cycle.
- Contradiction: line index 20 returns res_opts=0 -> error=1, busy=0, no requeue or commit; a later start clears error and restarts.
- Full stall and reset: fifo_full=1 during REQUEUE for 3 cycles -> fifo_wr_en stays 0, then pulses once when full drops. Asserting rst while in WAIT_RES -> next cycle all outputs 0, state IDLE, and a subsequent res_valid is ignored.
